// File: rtl/instruction_loader_pkg.sv
// Shared definitions for the instruction loader: word type, memory sizing
// and the loader FSM state encoding.
package instruction_loader_pkg;

  localparam int IM_WORDS    = 1024;
  localparam int IM_SIZE_BIT = $clog2(IM_WORDS) + 2;

  typedef logic [31:0] int_t;

  typedef enum logic [1:0] {
    LOADER_IDLE,
    LOADER_RECEIVE,
    LOADER_WRITE,
    LOADER_DONE
  } loader_state_t;

endpackage

// File: rtl/instruction_loader_packer.sv
// Collects four little-endian bytes into a 32-bit word; wordReady_o flags the
// cycle in which the fourth byte is accepted, with the completed word on word_o.
module byte_to_word_packer
  import instruction_loader_pkg::*;
(
  input  logic       clock,
  input  logic       reset,
  input  logic       clear_i,
  input  logic       byteAccept_i,
  input  logic [7:0] byteData_i,
  output logic       wordReady_o,
  output int_t       word_o
);

  logic [1:0] byteIndex_q, byteIndex_d;
  int_t       shift_q, shift_d;

  // Bytes enter at the top and shift down, so byte 0 ends up in bits [7:0].
  always_comb begin
    byteIndex_d = byteIndex_q;
    shift_d     = shift_q;
    if (clear_i) begin
      byteIndex_d = '0;
      shift_d     = '0;
    end else if (byteAccept_i) begin
      byteIndex_d = byteIndex_q + 2'd1;
      shift_d     = {byteData_i, shift_q[31:8]};
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      byteIndex_q <= '0;
      shift_q     <= '0;
    end else begin
      byteIndex_q <= byteIndex_d;
      shift_q     <= shift_d;
    end
  end

  assign wordReady_o = byteAccept_i && (byteIndex_q == 2'd3);
  assign word_o      = {byteData_i, shift_q[31:8]};

endmodule

// File: rtl/instruction_loader.sv
// Writer side of instruction memory: turns a byte stream into sequential word
// writes starting at address 0 and holds the CPU until the image is loaded.
module instruction_loader #(
  parameter int IM_WORDS  = instruction_loader_pkg::IM_WORDS,
  parameter int ADDR_BITS = $clog2(IM_WORDS)
) (
  input  logic                        clock,
  input  logic                        reset,
  input  logic                        start,
  input  logic [ADDR_BITS:0]          wordCount,
  input  logic                        byteValid,
  input  logic [7:0]                  byteData,
  output logic                        byteReady,
  output logic                        writeEnable,
  output logic [ADDR_BITS-1:0]        writeAddress,
  output instruction_loader_pkg::int_t writeData,
  output logic                        cpuHold,
  output logic                        busy,
  output logic                        done,
  output logic                        error
);

  import instruction_loader_pkg::*;

  localparam logic [ADDR_BITS:0] MAX_COUNT = (ADDR_BITS + 1)'(IM_WORDS);
  localparam logic [ADDR_BITS:0] ONE       = {{ADDR_BITS{1'b0}}, 1'b1};

  loader_state_t        state_q;
  logic [ADDR_BITS:0]   wordIdx_q;
  logic [ADDR_BITS:0]   count_q;
  logic                 writeEnable_q, cpuHold_q, busy_q, done_q, error_q;
  logic [ADDR_BITS-1:0] writeAddress_q;
  int_t                 writeData_q;

  logic countLegal, startAccept, byteAccept, wordReady;
  int_t packedWord;

  assign countLegal  = (wordCount != '0) && (wordCount <= MAX_COUNT);
  assign startAccept = (state_q == LOADER_IDLE) && start && countLegal;
  assign byteReady   = (state_q == LOADER_RECEIVE);
  assign byteAccept  = byteValid && byteReady;

  byte_to_word_packer u_packer (
    .clock        (clock),
    .reset        (reset),
    .clear_i      (startAccept),
    .byteAccept_i (byteAccept),
    .byteData_i   (byteData),
    .wordReady_o  (wordReady),
    .word_o       (packedWord)
  );

  // The word index is one bit wider than the address so a full-memory load
  // ends in DONE rather than wrapping back to address 0.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q        <= LOADER_IDLE;
      wordIdx_q      <= '0;
      count_q        <= '0;
      writeEnable_q  <= 1'b0;
      writeAddress_q <= '0;
      writeData_q    <= '0;
      cpuHold_q      <= 1'b0;
      busy_q         <= 1'b0;
      done_q         <= 1'b0;
      error_q        <= 1'b0;
    end else begin
      writeEnable_q <= 1'b0;
      done_q        <= 1'b0;
      case (state_q)
        LOADER_IDLE: begin
          if (start) begin
            if (countLegal) begin
              state_q   <= LOADER_RECEIVE;
              wordIdx_q <= '0;
              count_q   <= wordCount;
              busy_q    <= 1'b1;
              cpuHold_q <= 1'b1;
              error_q   <= 1'b0;
            end else begin
              error_q <= 1'b1;
            end
          end
        end
        LOADER_RECEIVE: begin
          if (wordReady) begin
            state_q        <= LOADER_WRITE;
            writeEnable_q  <= 1'b1;
            writeAddress_q <= wordIdx_q[ADDR_BITS-1:0];
            writeData_q    <= packedWord;
          end
        end
        LOADER_WRITE: begin
          wordIdx_q <= wordIdx_q + ONE;
          if (wordIdx_q == count_q - ONE) begin
            state_q <= LOADER_DONE;
            done_q  <= 1'b1;
          end else begin
            state_q <= LOADER_RECEIVE;
          end
        end
        LOADER_DONE: begin
          state_q   <= LOADER_IDLE;
          busy_q    <= 1'b0;
          cpuHold_q <= 1'b0;
        end
        default: state_q <= LOADER_IDLE;
      endcase
    end
  end

  assign writeEnable  = writeEnable_q;
  assign writeAddress = writeAddress_q;
  assign writeData    = writeData_q;
  assign cpuHold      = cpuHold_q;
  assign busy         = busy_q;
  assign done         = done_q;
  assign error        = error_q;

endmodule
